dbg_state_dumper: RTL and testbench
===================================

// Module: dbg_state_dumper
// PURPOSE
//  Synthesisable successor to bench-side register/memory printing. On a start
//  request it walks the CPU register file, then a data-memory window, and
//  streams one word per beat over a valid/ready port. Sits beside Pipe_CPU_1,
//  on the RF debug read port and the DM debug read port.
// PARAMETERS
//  DATA_W        32  width of register/memory words and of out_data_o
//  NUM_REGS      32  registers dumped, indices 0..NUM_REGS-1 (>=1)
//  RF_AW         5   register address width, 2**RF_AW >= NUM_REGS
//  NUM_MEM_WORDS 32  memory words dumped (>=1)
//  DM_AW         32  data-memory byte-address width
//  MEM_BASE      0   byte address of first dumped memory word
//  MEM_STRIDE    4   byte step between dumped memory words
//  IDX_W         8   width of out_idx_o, >= clog2(max(NUM_REGS,NUM_MEM_WORDS))
//  AUTO_REARM    0   1: start a new dump automatically after each done
// PORTS
//  clk_i       in   1       clock, rising edge
//  rst_i       in   1       asynchronous reset, active-high
//  start_i     in   1       dump request, sampled in IDLE only
//  rf_addr_o   out  RF_AW   register read address
//  rf_data_i   in   DATA_W  register read data, combinational from rf_addr_o
//  dm_addr_o   out  DM_AW   memory byte read address
//  dm_data_i   in   DATA_W  memory read data, combinational from dm_addr_o
//  out_valid_o out  1       beat valid
//  out_ready_i in   1       sink ready; beat transfers when valid && ready
//  out_data_o  out  DATA_W  beat payload
//  out_tag_o   out  2       2'b00 header, 2'b01 register, 2'b10 memory
//  out_idx_o   out  IDX_W   register index or memory word index
//  out_last_o  out  1       final beat of the dump
//  busy_o      out  1       high from start acceptance to done
//  done_o      out  1       one-cycle pulse in the cycle after the last transfer
// BEHAVIOUR
//  Reset (async, rst_i=1): state IDLE; out_valid_o, out_last_o, busy_o, done_o = 0;
//   rf_addr_o=0; dm_addr_o=MEM_BASE; out_data/tag/idx=0; counters=0.
//   Reset mid-dump discards the dump; no done_o pulse is issued.
//  FSM: IDLE -> (HDR) -> REG -> MEM -> DONE -> IDLE (or -> REG/HDR if AUTO_REARM).
//   IDLE: start_i=1 moves to first state next cycle, busy_o=1. start_i is ignored
//   while busy_o=1 and is not queued.
//   REG: rf_addr_o = idx. On load, out_data<=rf_data_i, tag 01, idx. After idx
//   NUM_REGS-1 loads, idx clears and state becomes MEM.
//   MEM: dm_addr_o = MEM_BASE + idx*MEM_STRIDE (mod 2**DM_AW). Load uses tag 10.
//   The NUM_MEM_WORDS-1 load sets out_last_o.
//   DONE is entered when the last beat transfers. done_o=1 and busy_o=0 for
//   that one cycle.
//  Output register: loads when !out_valid_o || out_ready_i, so throughput is
//   1 beat/cycle. While out_valid_o && !out_ready_i, the data, tag, idx and last
//   outputs hold and the address does not advance. Once raised, valid stays high
//   until transfer.
//  Latency: first beat valid 2 cycles after start_i is sampled. Total beats =
//   NUM_REGS + NUM_MEM_WORDS (+1 with header).
//  Addresses are only meaningful in REG/MEM. Outside them they hold their last value.
// CONFIGURATION
//  Macro DBG_DUMP_CYCLE_HDR_EN defined: a free-running DATA_W cycle counter is
//   built. It counts from reset and wraps. HDR state emits one beat first:
//   tag 00, idx 0, data = counter value in the start-acceptance cycle.
//  Not defined: no counter, no HDR state, tag 00 is never emitted.
// STRUCTURE
//  dbg_dump_pkg: state enum (IDLE,HDR,REG,MEM,DONE), TAG_HDR/TAG_REG/TAG_MEM.
//  Sub-module dbg_dump_out_stage: holding register plus valid/ready logic,
//   parametrised on DATA_W/IDX_W. The FSM and counters live in the top module.
// TESTING
//  1 NUM_REGS=4, NUM_MEM_WORDS=2, ready=1, RF[i]=i+10, DM words 0xA0,0xA1; start
//    -> beats (01,0,10)(01,1,11)(01,2,12)(01,3,13)(10,0,A0)(10,1,A1). Last is on
//    beat 6, dm_addr 0 then 4, and done_o pulses once.
//  2 As 1, out_ready_i low 3 cycles while beat 3 valid -> beat 3 fields stable,
//    6 beats total, no repeat or drop.
//  3 start_i pulsed again at beats 2 and 5 -> ignored; exactly 6 beats and 1 done.
//  4 rst_i asserted during beat 4 -> out_valid_o=0 and busy_o=0 same cycle, no
//    done_o. A new start restarts at reg 0.
//  5 DBG_DUMP_CYCLE_HDR_EN, start accepted at counter 37 -> first beat (00,0,37),
//    then 6 beats as in 1.
//  6 AUTO_REARM=1 -> after done_o, a second identical dump starts with no start_i.
//    busy_o is low only in the done cycle.

Source files
------------

// File: rtl/dbg_dump_pkg.sv
// Shared definitions for the debug state dumper.
//  state_t : dump sequencer states (IDLE, HDR, REG, MEM, DONE)
//  TAG_*   : beat tag encodings carried on out_tag_o
package dbg_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_REG  = 3'd2,
        ST_MEM  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] TAG_HDR = 2'b00;
    localparam logic [1:0] TAG_REG = 2'b01;
    localparam logic [1:0] TAG_MEM = 2'b10;

endpackage

// File: rtl/dbg_dump_out_stage.sv
// Single-entry output holding register with valid/ready handshake.
// Ports:
//  clk, rst        clock, asynchronous active-high reset
//  push, push_*    new beat offered by the sequencer (taken only when can_load)
//  ready           sink ready
//  can_load        register is empty or draining this cycle
//  valid, data, tag, idx, last   registered beat towards the sink
// The register refills in the same cycle it drains, giving one beat per cycle.
module dbg_dump_out_stage #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [1:0]        push_tag,
    input  logic [IDX_W-1:0]  push_idx,
    input  logic              push_last,
    input  logic              ready,
    output logic              can_load,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        tag,
    output logic [IDX_W-1:0]  idx,
    output logic              last
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [1:0]        tag_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              last_reg;

    assign can_load = !valid_reg || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            tag_reg   <= '0;
            idx_reg   <= '0;
            last_reg  <= 1'b0;
        end else if (push && can_load) begin
            valid_reg <= 1'b1;
            data_reg  <= push_data;
            tag_reg   <= push_tag;
            idx_reg   <= push_idx;
            last_reg  <= push_last;
        end else if (ready) begin
            // Drained with nothing new: payload fields hold their last value.
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;
    assign tag   = tag_reg;
    assign idx   = idx_reg;
    assign last  = last_reg;

endmodule

// File: rtl/dbg_state_dumper.sv
// Debug state dumper: on start, streams every CPU register and then a window
// of data-memory words over a valid/ready port, one word per beat.
// Ports:
//  clk_i, rst_i              clock, asynchronous active-high reset
//  start_i                   dump request, sampled only while idle
//  rf_addr_o / rf_data_i     register-file debug read port (combinational data)
//  dm_addr_o / dm_data_i     data-memory debug read port (byte address)
//  out_valid_o/out_ready_i   beat handshake
//  out_data_o, out_tag_o, out_idx_o, out_last_o   beat payload
//  busy_o                    dump in progress
//  done_o                    one-cycle pulse after the final beat transfers
// Build option: define DBG_DUMP_CYCLE_HDR_EN to prepend a header beat carrying
// a free-running cycle count captured when the dump was accepted.
module dbg_state_dumper
    import dbg_dump_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int NUM_REGS      = 32,
    parameter int RF_AW         = 5,
    parameter int NUM_MEM_WORDS = 32,
    parameter int DM_AW         = 32,
    parameter int MEM_BASE      = 0,
    parameter int MEM_STRIDE    = 4,
    parameter int IDX_W         = 8,
    parameter int AUTO_REARM    = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [RF_AW-1:0]  rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [DM_AW-1:0]  dm_addr_o,
    input  logic [DATA_W-1:0] dm_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        out_tag_o,
    output logic [IDX_W-1:0]  out_idx_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
);

`ifdef DBG_DUMP_CYCLE_HDR_EN
    localparam state_t FIRST_ST = ST_HDR;
`else
    localparam state_t FIRST_ST = ST_REG;
`endif

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg;
    logic              mem_done_reg;   // final memory beat already handed to the output stage
    logic [RF_AW-1:0]  rf_addr_reg;
    logic [DM_AW-1:0]  dm_addr_reg;
    logic [DATA_W-1:0] hdr_val;

    logic              can_load;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic [1:0]        push_tag;
    logic [IDX_W-1:0]  push_idx;
    logic              push_last;

    logic reg_final, mem_final, last_xfer, start_go;

    assign reg_final = (idx_reg == IDX_W'(NUM_REGS - 1));
    assign mem_final = (idx_reg == IDX_W'(NUM_MEM_WORDS - 1));
    assign last_xfer = out_valid_o && out_ready_i && out_last_o;
    // A dump is accepted from idle on request, or straight out of DONE when rearming.
    assign start_go  = ((state_reg == ST_IDLE) && start_i) ||
                       ((state_reg == ST_DONE) && (AUTO_REARM != 0));

`ifdef DBG_DUMP_CYCLE_HDR_EN
    logic [DATA_W-1:0] cycle_cnt_reg;
    logic [DATA_W-1:0] hdr_val_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt_reg <= '0;
            hdr_val_reg   <= '0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            if (start_go) begin
                hdr_val_reg <= cycle_cnt_reg;
            end
        end
    end

    assign hdr_val = hdr_val_reg;
`else
    assign hdr_val = '0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_i) state_next = FIRST_ST;
            ST_HDR:  if (can_load) state_next = ST_REG;
            ST_REG:  if (can_load && reg_final) state_next = ST_MEM;
            ST_MEM:  if (mem_done_reg && last_xfer) state_next = ST_DONE;
            ST_DONE: state_next = (AUTO_REARM != 0) ? FIRST_ST : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: beat offered to the output stage
    always_comb begin
        push      = 1'b0;
        push_data = rf_data_i;
        push_tag  = TAG_REG;
        push_idx  = idx_reg;
        push_last = 1'b0;
        case (state_reg)
            ST_HDR: begin
                push      = can_load;
                push_data = hdr_val;
                push_tag  = TAG_HDR;
                push_idx  = '0;
            end
            ST_REG: begin
                push = can_load;
            end
            ST_MEM: begin
                push      = can_load && !mem_done_reg;
                push_data = dm_data_i;
                push_tag  = TAG_MEM;
                push_last = mem_final;
            end
            default: begin
                push = 1'b0;
            end
        endcase
    end

    assign busy_o = (state_reg == ST_HDR) || (state_reg == ST_REG) || (state_reg == ST_MEM);
    assign done_o = (state_reg == ST_DONE);

    // Index and address counters. Addresses advance only when a beat is taken,
    // so a stalled sink freezes them; the memory address is kept as a running
    // sum rather than a multiply.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_reg      <= '0;
            mem_done_reg <= 1'b0;
            rf_addr_reg  <= '0;
            dm_addr_reg  <= DM_AW'(MEM_BASE);
        end else if (start_go) begin
            idx_reg      <= '0;
            mem_done_reg <= 1'b0;
            rf_addr_reg  <= '0;
            dm_addr_reg  <= DM_AW'(MEM_BASE);
        end else if (push && (state_reg == ST_REG)) begin
            if (reg_final) begin
                idx_reg <= '0;
            end else begin
                idx_reg     <= idx_reg + 1'b1;
                rf_addr_reg <= RF_AW'(idx_reg + 1'b1);
            end
        end else if (push && (state_reg == ST_MEM)) begin
            if (mem_final) begin
                mem_done_reg <= 1'b1;
            end else begin
                idx_reg     <= idx_reg + 1'b1;
                dm_addr_reg <= dm_addr_reg + DM_AW'(MEM_STRIDE);
            end
        end
    end

    assign rf_addr_o = rf_addr_reg;
    assign dm_addr_o = dm_addr_reg;

    dbg_dump_out_stage #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_out_stage (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (push_data),
        .push_tag  (push_tag),
        .push_idx  (push_idx),
        .push_last (push_last),
        .ready     (out_ready_i),
        .can_load  (can_load),
        .valid     (out_valid_o),
        .data      (out_data_o),
        .tag       (out_tag_o),
        .idx       (out_idx_o),
        .last      (out_last_o)
    );

endmodule

// File: tb/tb_dbg_state_dumper.sv
// Directed bench for dbg_state_dumper: 4 registers (RF[i]=i+10), 2 memory
// words (0xA0, 0xA1 at byte addresses 0 and 4). A second instance with
// AUTO_REARM=1 covers automatic restart.
module tb_dbg_state_dumper;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 8;
    localparam int RF_AW  = 5;
    localparam int DM_AW  = 32;
    localparam int NR     = 4;
    localparam int NM     = 2;
`ifdef DBG_DUMP_CYCLE_HDR_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif
    localparam int NB = NR + NM + H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, ready;
    logic [RF_AW-1:0]  rf_addr;
    logic [DATA_W-1:0] rf_data, dm_data, data;
    logic [DM_AW-1:0]  dm_addr;
    logic              valid, last, busy, done;
    logic [1:0]        tag;
    logic [IDX_W-1:0]  idx;

    logic              ar_rst, ar_start, ar_ready;
    logic [RF_AW-1:0]  ar_rf_addr;
    logic [DATA_W-1:0] ar_rf_data, ar_dm_data, ar_data;
    logic [DM_AW-1:0]  ar_dm_addr;
    logic              ar_valid, ar_last, ar_busy, ar_done;
    logic [1:0]        ar_tag;
    logic [IDX_W-1:0]  ar_idx;

    assign rf_data    = 32'(rf_addr) + 32'd10;
    assign dm_data    = 32'hA0 + (dm_addr >> 2);
    assign ar_rf_data = 32'(ar_rf_addr) + 32'd10;
    assign ar_dm_data = 32'hA0 + (ar_dm_addr >> 2);

    dbg_state_dumper #(
        .DATA_W(DATA_W), .NUM_REGS(NR), .RF_AW(RF_AW), .NUM_MEM_WORDS(NM),
        .DM_AW(DM_AW), .MEM_BASE(0), .MEM_STRIDE(4), .IDX_W(IDX_W), .AUTO_REARM(0)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .rf_addr_o(rf_addr), .rf_data_i(rf_data),
        .dm_addr_o(dm_addr), .dm_data_i(dm_data),
        .out_valid_o(valid), .out_ready_i(ready), .out_data_o(data),
        .out_tag_o(tag), .out_idx_o(idx), .out_last_o(last),
        .busy_o(busy), .done_o(done)
    );

    dbg_state_dumper #(
        .DATA_W(DATA_W), .NUM_REGS(NR), .RF_AW(RF_AW), .NUM_MEM_WORDS(NM),
        .DM_AW(DM_AW), .MEM_BASE(0), .MEM_STRIDE(4), .IDX_W(IDX_W), .AUTO_REARM(1)
    ) u_dut_ar (
        .clk_i(clk), .rst_i(ar_rst), .start_i(ar_start),
        .rf_addr_o(ar_rf_addr), .rf_data_i(ar_rf_data),
        .dm_addr_o(ar_dm_addr), .dm_data_i(ar_dm_data),
        .out_valid_o(ar_valid), .out_ready_i(ar_ready), .out_data_o(ar_data),
        .out_tag_o(ar_tag), .out_idx_o(ar_idx), .out_last_o(ar_last),
        .busy_o(ar_busy), .done_o(ar_done)
    );

    // Reference cycle count: cycles elapsed since reset released.
    int unsigned cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    // Drives one dump on u_dut, checks each transferred beat against the
    // expected sequence, and returns beat/done counts.
    task automatic run_dump(input string name, input int stall_beat, input int stall_len,
                            input int rs_a, input int rs_b,
                            output int nbeats, output int ndone);
        int n, post, stall_left, j;
        logic held;
        logic [DATA_W-1:0] hd, hv, ed;
        logic [1:0] ht, et;
        logic [IDX_W-1:0] hi, ei;
        logic hl, el;
        n = 0; ndone = 0; post = -1; stall_left = stall_len; held = 1'b0;
        hd = '0; ht = '0; hi = '0; hl = 1'b0; hv = '0;
        @(negedge clk);
        for (int c = 0; c < 300; c++) begin
            start = (c == 0) || (valid && (n == rs_a || n == rs_b));
            ready = !(valid && n == stall_beat && stall_left > 0);
            if (c == 0) hv = cyc;
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
            end
            if (c == 2) begin
                checks++;
                if (valid !== 1'b1) begin errors++; $display("FAIL %s first_beat_latency: valid=%b want 1", name, valid); end
            end
            if (!ready) begin
                if (!held) begin
                    hd = data; ht = tag; hi = idx; hl = last; held = 1'b1;
                end else begin
                    checks++;
                    if ({data, tag, idx, last} !== {hd, ht, hi, hl}) begin
                        errors++;
                        $display("FAIL %s stall_hold: got %h/%h/%h/%b want %h/%h/%h/%b", name, data, tag, idx, last, hd, ht, hi, hl);
                    end
                end
                stall_left--;
            end
            if (done) begin
                ndone++;
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_in_done: got %b want 0", name, busy); end
                if (post < 0) post = c;
            end
            if (valid && ready) begin
                if (n < H) begin
                    et = 2'b00; ei = '0; ed = hv; el = 1'b0;
                end else begin
                    j = n - H;
                    if (j < NR) begin et = 2'b01; ei = IDX_W'(j); ed = 32'd10 + 32'(j); end
                    else        begin et = 2'b10; ei = IDX_W'(j - NR); ed = 32'hA0 + 32'(j - NR); end
                    el = (j == NR + NM - 1);
                    if (j < NR - 1) begin
                        checks++;
                        if (rf_addr !== RF_AW'(j + 1)) begin errors++; $display("FAIL %s rf_addr beat%0d: got %0d want %0d", name, n, rf_addr, j + 1); end
                    end
                    if (j == NR - 1) begin
                        checks++;
                        if (dm_addr !== 32'd0) begin errors++; $display("FAIL %s dm_addr_first: got %0h want 0", name, dm_addr); end
                    end
                    if (j == NR + NM - 1) begin
                        checks++;
                        if (dm_addr !== 32'd4) begin errors++; $display("FAIL %s dm_addr_second: got %0h want 4", name, dm_addr); end
                    end
                end
                checks++;
                if (n >= NB) begin
                    errors++;
                    $display("FAIL %s extra_beat%0d: got tag %h idx %0d want no beat", name, n, tag, idx);
                end else if ({tag, idx, data, last} !== {et, ei, ed, el}) begin
                    errors++;
                    $display("FAIL %s beat%0d: got (%h,%0d,%h,last=%b) want (%h,%0d,%h,last=%b)", name, n, tag, idx, data, last, et, ei, ed, el);
                end
                n++;
            end
            if (post >= 0 && c >= post + 4) break;
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b1;
        if (post < 0) begin
            checks++; errors++;
            $display("FAIL %s done_timeout: got no done_o want one pulse", name);
        end
        nbeats = n;
        $display("%s: %0d beats, %0d done pulses", name, n, ndone);
    endtask

    task automatic test_reset();
        rst = 1'b1; ar_rst = 1'b1; start = 1'b0; ar_start = 1'b0; ready = 1'b1; ar_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({valid, last, busy, done} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {valid, last, busy, done}); end
        checks++;
        if (rf_addr !== '0 || dm_addr !== '0) begin errors++; $display("FAIL reset_addr: got rf %0d dm %0h want 0/0", rf_addr, dm_addr); end
        checks++;
        if (data !== '0 || tag !== '0 || idx !== '0) begin errors++; $display("FAIL reset_payload: got %h/%h/%h want 0", data, tag, idx); end
        rst = 1'b0; ar_rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic check_totals(input string name, input int nb, input int nd);
        checks++;
        if (nb !== NB) begin errors++; $display("FAIL %s beat_count: got %0d want %0d", name, nb, NB); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", name, nd); end
    endtask

    task automatic test_basic();
        int nb, nd;
        run_dump("basic", -1, 0, -1, -1, nb, nd);
        check_totals("basic", nb, nd);
    endtask

    task automatic test_stall();
        int nb, nd;
        run_dump("stall", 2 + H, 3, -1, -1, nb, nd);
        check_totals("stall", nb, nd);
    endtask

    task automatic test_restart_ignored();
        int nb, nd;
        run_dump("restart_ignored", -1, 0, 1 + H, 4 + H, nb, nd);
        check_totals("restart_ignored", nb, nd);
    endtask

    task automatic test_reset_mid();
        int nb, nd;
        logic found;
        found = 1'b0;
        @(negedge clk); start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (valid && tag == 2'b01 && idx == 3) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reset_mid reach_beat4: got none want reg 3 beat"); end
        rst = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid immediate: got valid %b busy %b want 0 0", valid, busy); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL reset_mid no_done: got %b want 0", done); end
        end
        rst = 1'b0;
        $display("reset_mid: reset applied during beat 4");
        run_dump("after_reset", -1, 0, -1, -1, nb, nd);
        check_totals("after_reset", nb, nd);
    endtask

`ifdef DBG_DUMP_CYCLE_HDR_EN
    task automatic test_hdr();
        int nb, nd;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100 && cyc != 36; i++) @(negedge clk);
        checks++;
        if (cyc != 36) begin errors++; $display("FAIL hdr align: got %0d want 36", cyc); end
        // run_dump starts on the next negedge, where the counter reads 37.
        run_dump("hdr37", -1, 0, -1, -1, nb, nd);
        check_totals("hdr37", nb, nd);
    endtask
`endif

    task automatic test_auto_rearm();
        int nb, nd, j;
        logic [1:0] et;
        logic [IDX_W-1:0] ei;
        logic [DATA_W-1:0] ed;
        nb = 0; nd = 0;
        ar_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 200 && nd < 2; c++) begin
            ar_start = (c == 0);
            if (c >= 1) begin
                checks++;
                if (ar_busy !== !ar_done) begin errors++; $display("FAIL auto_rearm busy c%0d: got busy %b done %b want busy=!done", c, ar_busy, ar_done); end
            end
            if (ar_done) nd++;
            if (ar_valid && ar_ready) begin
                j = nb % NB;
                if (j < H) begin et = 2'b00; ei = '0; ed = ar_data; end
                else if (j - H < NR) begin et = 2'b01; ei = IDX_W'(j - H); ed = 32'd10 + 32'(j - H); end
                else begin et = 2'b10; ei = IDX_W'(j - H - NR); ed = 32'hA0 + 32'(j - H - NR); end
                checks++;
                if ({ar_tag, ar_idx, ar_data} !== {et, ei, ed}) begin
                    errors++;
                    $display("FAIL auto_rearm beat%0d: got (%h,%0d,%h) want (%h,%0d,%h)", nb, ar_tag, ar_idx, ar_data, et, ei, ed);
                end
                nb++;
            end
            @(negedge clk);
        end
        ar_start = 1'b0;
        checks++;
        if (nd !== 2) begin errors++; $display("FAIL auto_rearm done_count: got %0d want 2", nd); end
        checks++;
        if (nb !== 2 * NB) begin errors++; $display("FAIL auto_rearm beat_count: got %0d want %0d", nb, 2 * NB); end
        ar_rst = 1'b1;
        $display("auto_rearm: %0d beats, %0d done pulses", nb, nd);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_restart_ignored();
        test_reset_mid();
`ifdef DBG_DUMP_CYCLE_HDR_EN
        test_hdr();
`endif
        test_auto_rearm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
